byte_stream_ram_writer: RTL and testbench

- Ingress stage that sits directly upstream of the bytewise block RAM and drives its addr/wr_ena/col_ena/wr_data port.
- Accepts a valid/ready byte stream, one frame at a time. Writes each byte into its byte lane using a one-hot column enable.
- On end of frame, writes a length header into word 0 and pulses frame_done, so a downstream reader can consume the buffered frame.

---
 rtl/byte_stream_ram_writer_if.sv | 77 +++++++
 rtl/byte_stream_ram_writer.sv | 189 ++++++++++++++++++
 tb/tb_byte_stream_ram_writer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_stream_ram_writer_if.sv
// ---------------------------------------------------------------------------
// byte_stream_ram_writer_if
//
// Purpose:
//   Groups the byte-stream handshake, the bytewise block-RAM write port and
//   the frame status outputs of byte_stream_ram_writer into one bundle.
//
// Parameters:
//   W   RAM row width in bits (multiple of 8, at least 16)
//   L   RAM depth in rows (row 0 is the length header)
//
// Signals:
//   in_valid    stream byte and in_last are valid
//   in_ready    writer can accept a byte this cycle
//   in_data     payload byte
//   in_last     final byte of the frame
//   addr        RAM row address
//   wr_ena      RAM write strobe
//   col_ena     RAM byte-lane enables (one bit per byte lane)
//   wr_data     RAM write data
//   frame_done  one-cycle pulse after the header write
//   frame_len   byte count of the last completed frame
//   overflow    current/last frame exceeded the payload capacity
//
// Modports:
//   master  stream source / status consumer (the environment)
//   slave   the writer itself
// ---------------------------------------------------------------------------
interface byte_stream_ram_writer_if #(
    parameter int W = 32,
    parameter int L = 375
);
    localparam int C  = W / 8;
    localparam int AW = $clog2(L);

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;

    logic [AW-1:0] addr;
    logic          wr_ena;
    logic [C-1:0]  col_ena;
    logic [W-1:0]  wr_data;

    logic          frame_done;
    logic [15:0]   frame_len;
    logic          overflow;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  addr,
        input  wr_ena,
        input  col_ena,
        input  wr_data,
        input  frame_done,
        input  frame_len,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output addr,
        output wr_ena,
        output col_ena,
        output wr_data,
        output frame_done,
        output frame_len,
        output overflow
    );
endinterface

// File: rtl/byte_stream_ram_writer.sv
// ---------------------------------------------------------------------------
// byte_stream_ram_writer
//
// Purpose:
//   Ingress stage sitting directly upstream of a bytewise block RAM. It takes
//   a valid/ready byte stream one frame at a time and writes each byte into
//   its own byte lane (one-hot column enable), filling rows 1..L-1. When the
//   last byte of a frame has been taken, the frame length is written into
//   row 0 and frame_done pulses so a reader can consume the buffered frame.
//   Bytes beyond the payload capacity are consumed but not written, and the
//   overflow flag is raised.
//
// Parameters:
//   W   RAM row width in bits (multiple of 8, at least 16)
//   L   RAM depth in rows
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    byte_stream_ram_writer_if slave modport:
//          in_valid/in_ready/in_data/in_last  byte stream
//          addr/wr_ena/col_ena/wr_data        RAM write port (registered)
//          frame_done/frame_len/overflow      frame status (registered)
// ---------------------------------------------------------------------------
module byte_stream_ram_writer #(
    parameter int W = 32,
    parameter int L = 375
) (
    input  logic                        clk,
    input  logic                        rst_n,
    byte_stream_ram_writer_if.slave     bus
);

    localparam int C   = W / 8;
    localparam int AW  = $clog2(L);
    localparam int CAP = (L - 1) * C;
    localparam int LW  = (C > 1) ? $clog2(C) : 1;

    localparam logic [15:0]   CAP16     = 16'(CAP);
    localparam logic [AW-1:0] FIRST_ROW = AW'(1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(L - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(C - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HDR,
        DONE
    } state_t;

    state_t        state_q;
    logic          inReady_q;
    logic [AW-1:0] addr_q;
    logic          wrEna_q;
    logic [C-1:0]  colEna_q;
    logic [W-1:0]  wrData_q;
    logic          frameDone_q;
    logic [15:0]   frameLen_q;
    logic          overflow_q;

    // Byte count of the frame in progress (saturates at CAP) plus the lane
    // and row the next payload byte lands in. Lane/row are tracked
    // incrementally so no divider is needed for non-power-of-two lane counts.
    logic [15:0]   cnt_q;
    logic [LW-1:0] lane_q;
    logic [AW-1:0] row_q;

    logic          accept_d;
    logic          room_d;
    logic [C-1:0]  laneOneHot_d;
    logic [W-1:0]  byteRep_d;
    logic [W-1:0]  hdrWord_d;

    // Handshake and write-word helpers. The header word carries the 16-bit
    // byte count zero-extended to the row width.
    always_comb begin
        accept_d             = bus.in_valid & inReady_q;
        room_d               = (cnt_q < CAP16);
        laneOneHot_d         = '0;
        laneOneHot_d[lane_q] = 1'b1;
        byteRep_d            = {C{bus.in_data}};
        hdrWord_d            = '0;
        hdrWord_d[15:0]      = cnt_q;
    end

    // Frame FSM with all outputs registered. IDLE holds in_ready low for the
    // single cycle after reset release; FILL writes payload bytes with one
    // cycle of latency; HDR writes the length into row 0; DONE publishes the
    // length and re-arms for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            inReady_q   <= 1'b0;
            addr_q      <= '0;
            wrEna_q     <= 1'b0;
            colEna_q    <= '0;
            wrData_q    <= '0;
            frameDone_q <= 1'b0;
            frameLen_q  <= '0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
            lane_q      <= '0;
            row_q       <= FIRST_ROW;
        end else begin
            case (state_q)
                IDLE: begin
                    inReady_q <= 1'b1;
                    state_q   <= FILL;
                end

                FILL: begin
                    frameDone_q <= 1'b0;
                    if (accept_d) begin
                        if (room_d) begin
                            addr_q   <= row_q;
                            colEna_q <= laneOneHot_d;
                            wrData_q <= byteRep_d;
                            wrEna_q  <= 1'b1;
                            cnt_q    <= cnt_q + 16'd1;
                            // The first byte of a new frame clears a stale
                            // overflow flag left by the previous frame.
                            if (cnt_q == 16'd0) begin
                                overflow_q <= 1'b0;
                            end
                            // Row advances when the lane wraps; the last
                            // payload row is never stepped past.
                            if (lane_q == LAST_LANE) begin
                                lane_q <= '0;
                                if (row_q != LAST_ROW) begin
                                    row_q <= row_q + AW'(1);
                                end
                            end else begin
                                lane_q <= lane_q + LW'(1);
                            end
                        end else begin
                            wrEna_q    <= 1'b0;
                            colEna_q   <= '0;
                            overflow_q <= 1'b1;
                        end
                        if (bus.in_last) begin
                            inReady_q <= 1'b0;
                            state_q   <= HDR;
                        end
                    end else begin
                        wrEna_q  <= 1'b0;
                        colEna_q <= '0;
                    end
                end

                HDR: begin
                    addr_q   <= '0;
                    wrEna_q  <= 1'b1;
                    colEna_q <= '1;
                    wrData_q <= hdrWord_d;
                    state_q  <= DONE;
                end

                DONE: begin
                    wrEna_q     <= 1'b0;
                    colEna_q    <= '0;
                    frameDone_q <= 1'b1;
                    frameLen_q  <= cnt_q;
                    cnt_q       <= '0;
                    lane_q      <= '0;
                    row_q       <= FIRST_ROW;
                    inReady_q   <= 1'b1;
                    state_q     <= FILL;
                end

                default: begin
                    inReady_q <= 1'b0;
                    wrEna_q   <= 1'b0;
                    colEna_q  <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = inReady_q;
    assign bus.addr       = addr_q;
    assign bus.wr_ena     = wrEna_q;
    assign bus.col_ena    = colEna_q;
    assign bus.wr_data    = wrData_q;
    assign bus.frame_done = frameDone_q;
    assign bus.frame_len  = frameLen_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_byte_stream_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_byte_stream_ram_writer
//
// Drives one byte stream into two writers in parallel: a full-size one
// (W=32, L=375) and a tiny one (W=32, L=3, capacity 8 bytes) so the
// overflow path can be reached with a short frame. RAM writes and frame
// completions of each instance are logged and compared against hand-built
// expected tables.
// ---------------------------------------------------------------------------
module tb_byte_stream_ram_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inValid = 1'b0;
    logic       inLast = 1'b0;
    logic [7:0] inData = 8'h00;

    int assertCount = 0;
    int failCount = 0;

    byte_stream_ram_writer_if #(.W(32), .L(375)) bigIf ();
    byte_stream_ram_writer_if #(.W(32), .L(3))   smallIf ();

    assign bigIf.in_valid   = inValid;
    assign bigIf.in_data    = inData;
    assign bigIf.in_last    = inLast;
    assign smallIf.in_valid = inValid;
    assign smallIf.in_data  = inData;
    assign smallIf.in_last  = inLast;

    byte_stream_ram_writer #(.W(32), .L(375)) dutBig (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bigIf)
    );

    byte_stream_ram_writer #(.W(32), .L(3)) dutSmall (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (smallIf)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Write / completion logs for both instances
    logic [15:0] bigAddr[$];
    logic [3:0]  bigCol[$];
    logic [31:0] bigData[$];
    logic [15:0] bigLen[$];
    logic [15:0] smallAddr[$];
    logic [3:0]  smallCol[$];
    logic [31:0] smallData[$];
    logic [15:0] smallLen[$];

    // Expected write table filled per scenario
    logic [15:0] expAddr[16];
    logic [3:0]  expCol[16];
    logic [31:0] expData[16];

    // Record every RAM write and every frame completion, sampled on the
    // falling edge so registered outputs are stable
    always @(negedge clk) begin
        if (bigIf.wr_ena) begin
            bigAddr.push_back(16'(bigIf.addr));
            bigCol.push_back(bigIf.col_ena);
            bigData.push_back(bigIf.wr_data);
        end
        if (bigIf.frame_done) begin
            bigLen.push_back(bigIf.frame_len);
        end
        if (smallIf.wr_ena) begin
            smallAddr.push_back(16'(smallIf.addr));
            smallCol.push_back(smallIf.col_ena);
            smallData.push_back(smallIf.wr_data);
        end
        if (smallIf.frame_done) begin
            smallLen.push_back(smallIf.frame_len);
        end
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte at a falling edge once in_ready is high; returns at
    // the falling edge after the accepting rising edge with in_valid still up
    task automatic applyStimulus(input logic [7:0] d, input logic last);
        int waitCycles;
        waitCycles = 0;
        while (!bigIf.in_ready && waitCycles < 20) begin
            inValid = 1'b0;
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("inReadyBeforeSend", 32'(bigIf.in_ready), 32'd1);
        inValid = 1'b1;
        inData  = d;
        inLast  = last;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        inValid = 1'b0;
        inLast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLogs();
        bigAddr.delete();
        bigCol.delete();
        bigData.delete();
        bigLen.delete();
        smallAddr.delete();
        smallCol.delete();
        smallData.delete();
        smallLen.delete();
    endtask

    task automatic setExp(input int i, input logic [15:0] a, input logic [3:0] c, input logic [31:0] d);
        expAddr[i] = a;
        expCol[i]  = c;
        expData[i] = d;
    endtask

    task automatic compareLog(input string tag, input int n, input bit useSmall);
        int got;
        got = useSmall ? smallAddr.size() : bigAddr.size();
        checkOutput($sformatf("%s_writeCount", tag), 32'(got), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            logic [3:0]  c;
            logic [31:0] d;
            a = 16'hffff;
            c = 4'h0;
            d = 32'hdeadbeef;
            if (i < got) begin
                if (useSmall) begin
                    a = smallAddr[i];
                    c = smallCol[i];
                    d = smallData[i];
                end else begin
                    a = bigAddr[i];
                    c = bigCol[i];
                    d = bigData[i];
                end
            end
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(a), 32'(expAddr[i]));
            checkOutput($sformatf("%s_col%0d", tag, i), 32'(c), 32'(expCol[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), d, expData[i]);
        end
    endtask

    function automatic logic [31:0] lenAt(input bit useSmall, input int i);
        if (useSmall) return (i < smallLen.size()) ? 32'(smallLen[i]) : 32'hdead;
        return (i < bigLen.size()) ? 32'(bigLen[i]) : 32'hdead;
    endfunction

    initial begin
        int lowCnt;

        // ---------------- reset state ----------------
        #2;
        checkOutput("rst_inReady", 32'(bigIf.in_ready), 32'd0);
        checkOutput("rst_addr", 32'(bigIf.addr), 32'd0);
        checkOutput("rst_wrEna", 32'(bigIf.wr_ena), 32'd0);
        checkOutput("rst_colEna", 32'(bigIf.col_ena), 32'd0);
        checkOutput("rst_wrData", bigIf.wr_data, 32'd0);
        checkOutput("rst_frameDone", 32'(bigIf.frame_done), 32'd0);
        checkOutput("rst_frameLen", 32'(bigIf.frame_len), 32'd0);
        checkOutput("rst_overflow", 32'(bigIf.overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_inReadyLow", 32'(bigIf.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("rel_inReadyHigh", 32'(bigIf.in_ready), 32'd1);

        // ---------------- five-byte frame ----------------
        clearLogs();
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h55, 1'b1);
        idleCycles(4);
        setExp(0, 16'd1, 4'b0001, 32'h11111111);
        setExp(1, 16'd1, 4'b0010, 32'h22222222);
        setExp(2, 16'd1, 4'b0100, 32'h33333333);
        setExp(3, 16'd1, 4'b1000, 32'h44444444);
        setExp(4, 16'd2, 4'b0001, 32'h55555555);
        setExp(5, 16'd0, 4'b1111, 32'h00000005);
        compareLog("five", 6, 1'b0);
        checkOutput("five_doneCount", 32'(bigLen.size()), 32'd1);
        checkOutput("five_frameLen", lenAt(1'b0, 0), 32'd5);
        checkOutput("five_frameLenHeld", 32'(bigIf.frame_len), 32'd5);
        checkOutput("five_overflow", 32'(bigIf.overflow), 32'd0);

        // ---------------- single-byte frame ----------------
        clearLogs();
        applyStimulus(8'hAB, 1'b1);
        inValid = 1'b0;
        lowCnt = 0;
        while (!bigIf.in_ready && lowCnt < 10) begin
            lowCnt++;
            @(negedge clk);
        end
        checkOutput("single_readyLowCycles", 32'(lowCnt), 32'd2);
        idleCycles(2);
        setExp(0, 16'd1, 4'b0001, 32'hABABABAB);
        setExp(1, 16'd0, 4'b1111, 32'h00000001);
        compareLog("single", 2, 1'b0);
        checkOutput("single_doneCount", 32'(bigLen.size()), 32'd1);
        checkOutput("single_frameLen", lenAt(1'b0, 0), 32'd1);

        // ---------------- in_valid toggling every other cycle ----------------
        clearLogs();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'(i + 1), (i == 5));
            checkOutput($sformatf("gap_wrEnaAfterAccept%0d", i), 32'(bigIf.wr_ena), 32'd1);
            if (i < 5) begin
                inValid = 1'b0;
                @(negedge clk);
                checkOutput($sformatf("gap_wrEnaIdle%0d", i), 32'(bigIf.wr_ena), 32'd0);
                checkOutput($sformatf("gap_colIdle%0d", i), 32'(bigIf.col_ena), 32'd0);
            end
        end
        idleCycles(4);
        setExp(0, 16'd1, 4'b0001, 32'h01010101);
        setExp(1, 16'd1, 4'b0010, 32'h02020202);
        setExp(2, 16'd1, 4'b0100, 32'h03030303);
        setExp(3, 16'd1, 4'b1000, 32'h04040404);
        setExp(4, 16'd2, 4'b0001, 32'h05050505);
        setExp(5, 16'd2, 4'b0010, 32'h06060606);
        setExp(6, 16'd0, 4'b1111, 32'h00000006);
        compareLog("gap", 7, 1'b0);

        // ---------------- overflow on the 8-byte instance ----------------
        clearLogs();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'(i + 1), (i == 9));
        end
        idleCycles(4);
        setExp(0, 16'd1, 4'b0001, 32'h01010101);
        setExp(1, 16'd1, 4'b0010, 32'h02020202);
        setExp(2, 16'd1, 4'b0100, 32'h03030303);
        setExp(3, 16'd1, 4'b1000, 32'h04040404);
        setExp(4, 16'd2, 4'b0001, 32'h05050505);
        setExp(5, 16'd2, 4'b0010, 32'h06060606);
        setExp(6, 16'd2, 4'b0100, 32'h07070707);
        setExp(7, 16'd2, 4'b1000, 32'h08080808);
        setExp(8, 16'd0, 4'b1111, 32'h00000008);
        compareLog("ovf", 9, 1'b1);
        checkOutput("ovf_smallFrameLen", lenAt(1'b1, 0), 32'd8);
        checkOutput("ovf_smallOverflow", 32'(smallIf.overflow), 32'd1);
        checkOutput("ovf_bigFrameLen", lenAt(1'b0, 0), 32'd10);
        checkOutput("ovf_bigOverflow", 32'(bigIf.overflow), 32'd0);
        applyStimulus(8'h77, 1'b0);
        checkOutput("ovf_clearedOnNextFrame", 32'(smallIf.overflow), 32'd0);
        applyStimulus(8'h78, 1'b1);
        idleCycles(4);

        // ---------------- back-to-back frames ----------------
        clearLogs();
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b0);
        applyStimulus(8'hA3, 1'b1);
        applyStimulus(8'hB1, 1'b0);
        applyStimulus(8'hB2, 1'b1);
        idleCycles(4);
        setExp(0, 16'd1, 4'b0001, 32'hA1A1A1A1);
        setExp(1, 16'd1, 4'b0010, 32'hA2A2A2A2);
        setExp(2, 16'd1, 4'b0100, 32'hA3A3A3A3);
        setExp(3, 16'd0, 4'b1111, 32'h00000003);
        setExp(4, 16'd1, 4'b0001, 32'hB1B1B1B1);
        setExp(5, 16'd1, 4'b0010, 32'hB2B2B2B2);
        setExp(6, 16'd0, 4'b1111, 32'h00000002);
        compareLog("b2b", 7, 1'b0);
        checkOutput("b2b_doneCount", 32'(bigLen.size()), 32'd2);
        checkOutput("b2b_frameLen0", lenAt(1'b0, 0), 32'd3);
        checkOutput("b2b_frameLen1", lenAt(1'b0, 1), 32'd2);

        // ---------------- reset in the middle of a frame ----------------
        clearLogs();
        applyStimulus(8'hC1, 1'b0);
        applyStimulus(8'hC2, 1'b0);
        applyStimulus(8'hC3, 1'b0);
        inValid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_inReady", 32'(bigIf.in_ready), 32'd0);
        checkOutput("midRst_addr", 32'(bigIf.addr), 32'd0);
        checkOutput("midRst_wrEna", 32'(bigIf.wr_ena), 32'd0);
        checkOutput("midRst_colEna", 32'(bigIf.col_ena), 32'd0);
        checkOutput("midRst_wrData", bigIf.wr_data, 32'd0);
        checkOutput("midRst_frameLen", 32'(bigIf.frame_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(3);
        checkOutput("midRst_noHeader", 32'(bigAddr.size()), 32'd3);
        checkOutput("midRst_noDone", 32'(bigLen.size()), 32'd0);
        clearLogs();
        applyStimulus(8'hD1, 1'b0);
        checkOutput("midRst_lenBeforeDone", 32'(bigIf.frame_len), 32'd0);
        applyStimulus(8'hD2, 1'b1);
        idleCycles(4);
        setExp(0, 16'd1, 4'b0001, 32'hD1D1D1D1);
        setExp(1, 16'd1, 4'b0010, 32'hD2D2D2D2);
        setExp(2, 16'd0, 4'b1111, 32'h00000002);
        compareLog("afterRst", 3, 1'b0);
        checkOutput("afterRst_frameLen", 32'(bigIf.frame_len), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
